// File: rtl/spi_pkg.sv
// Shared definitions for the SPI message link: word/length widths, TX FSM states, byte swap.
package spi_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned LEN_W  = 8;
   localparam int unsigned USED_W = 9;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StShift,
      StDone
   } tx_state_e;

   function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
      return {w[7:0], w[15:8]};
   endfunction

endpackage

// File: rtl/spi_msg_transmitter_if.sv
// Host-side write/command signals and serial TX outputs of the message transmitter.
interface spi_msg_transmitter_if;
   import spi_pkg::*;

   logic [WORD_W-1:0] DATA;
   logic              ENA;
   logic              SEND;
   logic [LEN_W-1:0]  MSG_LEN;
   logic              RX_STOP;
   logic              TX_DATA;
   logic              TX_LOAD;
   logic              BUSY;
   logic              DONE;
   logic              ERR;
   logic              OVF;
   logic [USED_W-1:0] FIFO_USED;

   modport master (
      output DATA, ENA, SEND, MSG_LEN, RX_STOP,
      input  TX_DATA, TX_LOAD, BUSY, DONE, ERR, OVF, FIFO_USED
   );

   modport slave (
      input  DATA, ENA, SEND, MSG_LEN, RX_STOP,
      output TX_DATA, TX_LOAD, BUSY, DONE, ERR, OVF, FIFO_USED
   );

endinterface

// File: rtl/spi_tx_fifo.sv
// Word buffer for the transmitter: synchronous FIFO with registered read data and a used count.
module spi_tx_fifo
   import spi_pkg::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [WORD_W-1:0] rd_data,
   output logic [USED_W-1:0] used,
   output logic              full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [USED_W-1:0] used_q;
   logic [WORD_W-1:0] rd_data_q;
   logic              push, pop;

   // A write at full is dropped even when a pop frees a slot in the same cycle.
   assign full = (used_q == USED_W'(DEPTH));
   assign push = wr_en && !full;
   assign pop  = rd_en && (used_q != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         used_q    <= '0;
         rd_data_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + AW'(1);
            rd_data_q <= mem[rd_ptr_q];
         end
         used_q <= used_q + USED_W'(push) - USED_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

   assign rd_data = rd_data_q;
   assign used    = used_q;

endmodule

// File: rtl/spi_msg_transmitter.sv
// Buffers 16-bit words and serialises a requested number of them MSB first, gated by RX_STOP.
module spi_msg_transmitter
   import spi_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 256,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input logic                  SYS_CLK,
   input logic                  RST,
   spi_msg_transmitter_if.slave bus
);

   tx_state_e         state_q, state_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic              err_q, err_d;
   logic              ovf_q;
   logic              pop;
   logic [WORD_W-1:0] fifo_rd_data;
   logic [USED_W-1:0] fifo_used;
   logic              fifo_full;

   spi_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (SYS_CLK),
      .rst     (RST),
      .wr_en   (bus.ENA),
      .wr_data (bus.DATA),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .used    (fifo_used),
      .full    (fifo_full)
   );

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      err_d     = 1'b0;
      pop       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.SEND && (bus.MSG_LEN != '0)) begin
               if (fifo_used >= USED_W'(bus.MSG_LEN)) begin
                  rem_d   = bus.MSG_LEN;
                  state_d = StFetch;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StFetch: begin
            if (!bus.RX_STOP) begin
               pop     = 1'b1;
               state_d = StLoad;
            end
         end
         StLoad: begin
            shreg_d   = BIG_ENDIAN ? fifo_rd_data : byte_swap(fifo_rd_data);
            bit_cnt_d = '0;
            state_d   = StShift;
         end
         StShift: begin
            shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
               rem_d   = rem_q - LEN_W'(1);
               state_d = (rem_q == LEN_W'(1)) ? StDone : StFetch;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge SYS_CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         rem_q     <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         err_q     <= err_d;
         ovf_q     <= bus.ENA && fifo_full;
      end
   end

   assign bus.TX_LOAD   = (state_q == StShift);
   assign bus.TX_DATA   = (state_q == StShift) && shreg_q[WORD_W-1];
   assign bus.BUSY      = (state_q != StIdle);
   assign bus.DONE      = (state_q == StDone);
   assign bus.ERR       = err_q;
   assign bus.OVF       = ovf_q;
   assign bus.FIFO_USED = fifo_used;

endmodule

// File: tb/tb_spi_msg_transmitter.sv
// Bench: two transmitters (depth 256 big-endian, depth 4 byte-swapping) driven in lockstep
// against a schedule-based reference model of FIFO contents and serial timing.
module tb_spi_msg_transmitter;
   import spi_pkg::*;

   localparam int unsigned DEPTH_A = 256;
   localparam int unsigned DEPTH_B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_r, ena_r, send_r, stop_r;
   logic [15:0] data_r;
   logic [7:0]  len_r;

   spi_msg_transmitter_if bus_a ();
   spi_msg_transmitter_if bus_b ();

   assign bus_a.DATA    = data_r;
   assign bus_a.ENA     = ena_r;
   assign bus_a.SEND    = send_r;
   assign bus_a.MSG_LEN = len_r;
   assign bus_a.RX_STOP = stop_r;
   assign bus_b.DATA    = data_r;
   assign bus_b.ENA     = ena_r;
   assign bus_b.SEND    = send_r;
   assign bus_b.MSG_LEN = len_r;
   assign bus_b.RX_STOP = stop_r;

   spi_msg_transmitter #(
      .FIFO_DEPTH (DEPTH_A),
      .BIG_ENDIAN (1'b1)
   ) dut_a (
      .SYS_CLK (clk),
      .RST     (rst_r),
      .bus     (bus_a)
   );

   spi_msg_transmitter #(
      .FIFO_DEPTH (DEPTH_B),
      .BIG_ENDIAN (1'b0)
   ) dut_b (
      .SYS_CLK (clk),
      .RST     (rst_r),
      .bus     (bus_b)
   );

   wire [1:0] o_load = {bus_b.TX_LOAD, bus_a.TX_LOAD};
   wire [1:0] o_data = {bus_b.TX_DATA, bus_a.TX_DATA};
   wire [1:0] o_busy = {bus_b.BUSY, bus_a.BUSY};
   wire [1:0] o_done = {bus_b.DONE, bus_a.DONE};
   wire [1:0] o_err  = {bus_b.ERR, bus_a.ERR};
   wire [1:0] o_ovf  = {bus_b.OVF, bus_a.OVF};
   wire [8:0] used_a = bus_a.FIFO_USED;
   wire [8:0] used_b = bus_b.FIFO_USED;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: buffered words per DUT, pending OVF, words popped for the current message.
   logic [15:0] mq0[$];
   logic [15:0] mq1[$];
   bit          ovf_exp [2];
   logic [15:0] popped  [2];
   logic [15:0] sent    [2][256];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_cycle(input int d, input bit ld, input bit bt, input bit bsy,
                              input bit dn, input bit er);
      check($sformatf("tx_load%0d", d), o_load[d], ld);
      check($sformatf("tx_data%0d", d), o_data[d], bt);
      check($sformatf("busy%0d", d), o_busy[d], bsy);
      check($sformatf("done%0d", d), o_done[d], dn);
      check($sformatf("err%0d", d), o_err[d], er);
      check($sformatf("ovf%0d", d), o_ovf[d], ovf_exp[d]);
      if (d == 0) check("fifo_used0", used_a, mq0.size());
      else        check("fifo_used1", used_b, mq1.size());
   endtask

   // Drive one cycle of inputs, advance one edge, apply the FIFO rules to the model.
   task automatic step(input bit ena, input logic [15:0] data, input bit snd,
                       input logic [7:0] len, input bit stop, input bit rst, input bit [1:0] pop);
      bit full0, full1;
      ena_r  = ena;
      data_r = data;
      send_r = snd;
      len_r  = len;
      stop_r = stop;
      rst_r  = rst;
      @(posedge clk);
      ovf_exp[0] = 1'b0;
      ovf_exp[1] = 1'b0;
      if (rst) begin
         mq0.delete();
         mq1.delete();
      end else begin
         full0 = (mq0.size() == DEPTH_A);
         full1 = (mq1.size() == DEPTH_B);
         if (pop[0] && mq0.size() > 0) popped[0] = mq0.pop_front();
         if (pop[1] && mq1.size() > 0) popped[1] = mq1.pop_front();
         if (ena) begin
            if (full0) ovf_exp[0] = 1'b1;
            else       mq0.push_back(data);
            if (full1) ovf_exp[1] = 1'b1;
            else       mq1.push_back(data);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b1, 2'b00);
      for (int d = 0; d < 2; d++) check_cycle(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic write_word(input logic [15:0] w);
      step(1'b1, w, 1'b0, 8'h0, 1'b0, 1'b0, 2'b00);
      for (int d = 0; d < 2; d++) check_cycle(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Schedule, cycles counted from SEND (c=0): word k fetch starts at F_k (F_0=1), pops at
   // P_k = F_k + stall_k, shifts P_k+2..P_k+17, next fetch at P_k+18; DONE at P_last+18.
   task automatic run_msg(input bit do_send, input int unsigned len, input int stall_word,
                          input int unsigned stall_len, input int unsigned wr_pct,
                          input int unsigned abort_c);
      int unsigned p [256];
      int unsigned f, dcyc, last;
      bit          acc [2];
      bit          rej [2];
      bit          ab;
      int unsigned sz [2];
      sz[0] = mq0.size();
      sz[1] = mq1.size();
      for (int d = 0; d < 2; d++) begin
         acc[d] = do_send && (len != 0) && (sz[d] >= len);
         rej[d] = do_send && (len != 0) && (sz[d] < len);
      end
      f = 1;
      for (int k = 0; k < int'(len); k++) begin
         p[k] = f + ((k == stall_word) ? stall_len : 0);
         f    = p[k] + 18;
      end
      dcyc = f;
      last = (acc[0] || acc[1]) ? dcyc + 1 : 2;
      ab   = 1'b0;
      for (int unsigned c = 0; c < last; c++) begin
         bit          ena, snd, stop, rst;
         bit [1:0]    pop;
         logic [15:0] data;
         logic [7:0]  ln;
         int          cur;
         int unsigned fk, x;
         rst  = (abort_c != 0) && (c == abort_c);
         ena  = !rst && ($urandom_range(99) < wr_pct);
         data = 16'($urandom);
         snd  = (c == 0) ? do_send :
                (acc[0] && acc[1] && !ab && !rst && c <= dcyc && $urandom_range(7) == 0);
         ln   = (c == 0) ? len[7:0] : 8'($urandom_range(3, 1));
         stop = 1'($urandom_range(1));
         pop  = 2'b00;
         cur  = 0;
         if (acc[0] || acc[1]) begin
            for (int k = 0; k < int'(len); k++) begin
               fk = (k == 0) ? 1 : p[k-1] + 18;
               if (c >= fk && c < p[k]) stop = 1'b1;
               if (c == p[k]) begin
                  stop = 1'b0;
                  pop  = {acc[1], acc[0]};
                  cur  = k;
               end
            end
         end
         if (ab || rst) pop = 2'b00;
         step(ena, data, snd, ln, stop, rst, pop);
         if (rst) ab = 1'b1;
         for (int d = 0; d < 2; d++) if (pop[d]) sent[d][cur] = popped[d];
         x = c + 1;
         for (int d = 0; d < 2; d++) begin
            bit          e_ld, e_bt, e_bsy, e_dn, e_er;
            logic [15:0] w;
            e_ld  = 1'b0;
            e_bt  = 1'b0;
            e_bsy = 1'b0;
            e_dn  = 1'b0;
            e_er  = !ab && rej[d] && (x == 1);
            if (acc[d] && !ab) begin
               e_bsy = (x >= 1) && (x <= dcyc);
               e_dn  = (x == dcyc);
               for (int k = 0; k < int'(len); k++) begin
                  if (x >= p[k] + 2 && x <= p[k] + 17) begin
                     w = sent[d][k];
                     if (d == 1) w = {w[7:0], w[15:8]};
                     e_ld = 1'b1;
                     e_bt = w[15 - (x - p[k] - 2)];
                  end
               end
            end
            check_cycle(d, e_ld, e_bt, e_bsy, e_dn, e_er);
         end
         if (ab && c >= abort_c + 3) break;
      end
      ena_r  = 1'b0;
      send_r = 1'b0;
      stop_r = 1'b0;
      rst_r  = 1'b0;
   endtask

   initial begin
      do_reset();

      // Two known words, no flow control.
      write_word(16'hA55A);
      write_word(16'h1234);
      run_msg(1'b1, 2, -1, 0, 0, 0);

      // Far end stalls 10 cycles before word 2 of 3.
      for (int i = 0; i < 3; i++) write_word(16'($urandom));
      run_msg(1'b1, 3, 1, 10, 0, 0);

      // Rejected and ignored requests, then drain.
      write_word(16'($urandom));
      run_msg(1'b1, 2, -1, 0, 0, 0);
      run_msg(1'b1, 0, -1, 0, 0, 0);
      run_msg(1'b1, 1, -1, 0, 0, 0);

      // Five writes overflow the depth-4 buffer; reset during bit 7 of the first word.
      for (int i = 0; i < 5; i++) write_word(16'($urandom));
      run_msg(1'b1, 3, -1, 0, 0, 10);
      run_msg(1'b0, 0, -1, 0, 0, 0);

      for (int it = 0; it < 40; it++) begin
         int unsigned nw;
         nw = $urandom_range(4);
         for (int i = 0; i < int'(nw); i++) write_word(16'($urandom));
         run_msg(1'b1, $urandom_range(5), int'($urandom_range(4)), $urandom_range(8), 25, 0);
      end

      // Longest message.
      do_reset();
      for (int i = 0; i < 255; i++) write_word(16'($urandom));
      run_msg(1'b1, 255, -1, 0, 10, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
